// File: rtl/inst_fetch.sv
// inst_fetch: RV32I instruction fetch stage.
// Owns the program counter and issues word reads over a valid/ready request
// channel. In-order responses are buffered in a small FIFO that feeds decode,
// along with each instruction's PC and a pre-decoded immediate-type code.
// A redirect flushes the FIFO. Responses already in flight at that moment
// are dropped silently when they return.
//
// Optional feature macro: INST_FETCH_MISALIGN_CHECK_EN
//   defined   - a misaligned redirect halts fetch and queues one marker entry
//               {NOP, redirect_pc, misalign=1}. The next aligned redirect
//               resumes fetch.
//   undefined - redirect_pc[1:0] is ignored and if_misalign is tied low.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [2:0]  if_imm_type,
  output logic        if_misalign
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [CW-1:0] inflight_reg;
  logic [CW-1:0] drop_reg;
  logic [CW-1:0] count_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [CW:0]   credit_sum;
  logic          halted;
  logic          req_fire;
  logic          rsp_accept;
  logic          rsp_push;
  logic          pop;
  logic          marker_write;
  logic [31:0]   aligned_pc;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_inst;
  logic [31:0]   wr_pc;
  logic [2:0]    imm_type;

  // The low two bits are masked for the PC registers in both builds.
  assign aligned_pc = redirect_pc & ~32'h3;

  // Credit rule: outstanding requests plus buffered entries never exceed the
  // FIFO depth. This guarantees every response has a free slot.
  assign credit_sum     = {1'b0, inflight_reg} + {1'b0, count_reg};
  assign imem_req_valid = !rst && !redirect_valid && !halted && (credit_sum < DEPTH_C);
  assign imem_addr      = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_accept = imem_rsp_valid && (inflight_reg != '0);
  assign rsp_push   = rsp_accept && (drop_reg == '0);
  assign pop        = if_valid && if_ready && !redirect_valid;

  assign if_valid = (count_reg != '0);
  assign if_inst  = if_valid ? inst_mem[rd_ptr_reg] : NOP;
  assign if_pc    = if_valid ? pc_mem[rd_ptr_reg] : 32'h0;

`ifdef INST_FETCH_MISALIGN_CHECK_EN
  logic             halted_reg;
  logic [DEPTH-1:0] mis_mem;

  assign halted       = halted_reg;
  assign marker_write = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign if_misalign  = if_valid && mis_mem[rd_ptr_reg];

  // Halt flag: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_reg <= 1'b0;
    end else if (redirect_valid) begin
      halted_reg <= marker_write;
    end
  end

  // Misalign marker bit alongside each FIFO entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mis_mem[wr_idx] <= marker_write;
    end
  end
`else
  assign halted       = 1'b0;
  assign marker_write = 1'b0;
  assign if_misalign  = 1'b0;
`endif

  // FIFO write port: either a live response or the misalign marker.
  always_comb begin
    wr_en   = (rsp_push && !redirect_valid) || marker_write;
    wr_idx  = marker_write ? '0 : wr_ptr_reg;
    wr_inst = marker_write ? NOP : imem_rsp_data;
    wr_pc   = marker_write ? redirect_pc : rsp_pc_reg;
  end

  // FIFO storage: plain register array without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem[wr_idx] <= wr_inst;
      pc_mem[wr_idx]   <= wr_pc;
    end
  end

  // PC, in-flight/drop bookkeeping and FIFO pointers. A redirect wins over
  // everything else in its cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= aligned_pc;
      rsp_pc_reg   <= aligned_pc;
      // No request fires in a redirect cycle. A response arriving now is
      // discarded, so only the remaining ones need dropping.
      inflight_reg <= inflight_reg - CW'(rsp_accept);
      drop_reg     <= inflight_reg - CW'(rsp_accept);
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= marker_write ? AW'(1) : '0;
      count_reg    <= marker_write ? CW'(1) : '0;
    end else begin
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      inflight_reg <= inflight_reg + CW'(req_fire) - CW'(rsp_accept);
      if (rsp_accept && (drop_reg != '0)) begin
        drop_reg <= drop_reg - CW'(1);
      end
      if (rsp_push) begin
        rsp_pc_reg <= rsp_pc_reg + 32'd4;
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(rsp_push) - CW'(pop);
    end
  end

  // Immediate-type pre-decode from the head opcode.
  always_comb begin
    imm_type = 3'd0;
    case (if_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: imm_type = 3'd1;
      7'b0100011:                                     imm_type = 3'd2;
      7'b1100011:                                     imm_type = 3'd3;
      7'b0110111, 7'b0010111:                         imm_type = 3'd4;
      7'b1101111:                                     imm_type = 3'd5;
      default:                                        imm_type = 3'd0;
    endcase
  end

  assign if_imm_type = if_valid ? imm_type : 3'd0;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scoreboard bench for inst_fetch.
// A behavioural memory answers requests in order after a programmable
// latency. The stimulus pushes hand-computed expected entries, and a
// separate monitor pops and compares each entry accepted by decode.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [2:0]  if_imm_type;
  logic        if_misalign;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_imm_type    (if_imm_type),
    .if_misalign    (if_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  imm;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  int    checks     = 0;
  int    failures   = 0;
  int    mem_lat    = 1;
  int    fire_count = 0;
  int    cyc        = 0;

  // Memory contents: a few fixed encodings, otherwise an R-type word tagged by its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093; // addi x1,x0,5
      32'h0000_0004: return 32'h0010_2023; // sw   x1,0(x0)
      32'h0000_0008: return 32'h0000_0463; // beq  x0,x0,8
      32'h0000_000C: return 32'h1234_5137; // lui  x2,0x12345
      32'h0000_0010: return 32'h0000_006F; // jal  x0,0
      32'h0000_0014: return 32'h0020_81B3; // add  x3,x1,x2
      32'h0000_0100: return 32'h0000_A103; // lw   x2,0(x1)
      32'h0000_0104: return 32'h0000_1297; // auipc x5,1
      32'h0000_0108: return 32'h0000_8067; // jalr x0,0(x1)
      32'h0000_0300: return 32'h0000_0073; // ecall
      default:       return {a[23:0], 8'h33};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [2:0] imm, input logic mis);
    exp_t e;
    e.pc = pc; e.inst = inst; e.imm = imm; e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic redir_on(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    exp_q.delete();
  endtask

  task automatic redir_off();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain actual=%0d_left required=0_left", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory model: samples handshakes mid-cycle and answers in order after mem_lat cycles.
  initial begin
    logic  fire;
    logic  rst_s;
    logic [31:0] faddr;
    pend_t p;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      fire  = imem_req_valid && imem_req_ready;
      faddr = imem_addr;
      rst_s = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_s) begin
        pend_q.delete();
        fire_count = 0;
      end else begin
        if (imem_rsp_valid && pend_q.size() != 0) void'(pend_q.pop_front());
        if (fire) begin
          p.addr = faddr;
          p.due  = cyc - 1 + mem_lat;
          pend_q.push_back(p);
          fire_count++;
        end
      end
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Monitor: compares every entry decode accepts against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && if_valid && if_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual=pc_%h required=no_entry", if_pc);
        end else begin
          e = exp_q.pop_front();
          $display("pop pc=%h inst=%h imm=%0d mis=%0b", if_pc, if_inst, if_imm_type, if_misalign);
          chk("pop_pc",   if_pc, e.pc);
          chk("pop_inst", if_inst, e.inst);
          chk("pop_imm",  {29'h0, if_imm_type}, {29'h0, e.imm});
          chk("pop_mis",  {31'h0, if_misalign}, {31'h0, e.mis});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    rst            = 1'b1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick(3);

    // Reset state.
    @(negedge clk);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_addr",      imem_addr, 32'h0);
    chk("rst_if_valid",  {31'h0, if_valid}, 32'h0);
    chk("rst_if_inst",   if_inst, 32'h0000_0013);
    chk("rst_if_pc",     if_pc, 32'h0);
    chk("rst_imm_type",  {29'h0, if_imm_type}, 32'h0);
    chk("rst_misalign",  {31'h0, if_misalign}, 32'h0);
    tick(1);

    // Phase A: 1-cycle memory, sequential fetch from 0 and imm-type decode.
    rst      = 1'b0;
    if_ready = 1'b1;
    exp_push(32'h00, 32'h0050_0093, 3'd1, 1'b0);
    exp_push(32'h04, 32'h0010_2023, 3'd2, 1'b0);
    exp_push(32'h08, 32'h0000_0463, 3'd3, 1'b0);
    exp_push(32'h0C, 32'h1234_5137, 3'd4, 1'b0);
    exp_push(32'h10, 32'h0000_006F, 3'd5, 1'b0);
    exp_push(32'h14, 32'h0020_81B3, 3'd0, 1'b0);
    @(negedge clk);
    chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("first_req_addr",  imem_addr, 32'h0);
    drain("seq");
    if_ready = 1'b0;

    // Phase B: decode stalled; credits exhausted and head held stable.
    tick(6);
    @(negedge clk);
    chk("stall_req_valid",  {31'h0, imem_req_valid}, 32'h0);
    chk("stall_fire_count", fire_count, 32'd8);
    chk("stall_head_pc",    if_pc, 32'h18);
    tick(3);
    @(negedge clk);
    chk("stall_hold_pc",    if_pc, 32'h18);
    chk("stall_hold_inst",  if_inst, 32'h0000_1833);
    chk("stall_hold_valid", {31'h0, if_valid}, 32'h1);
    tick(1);
    if_ready = 1'b1;
    exp_push(32'h18, 32'h0000_1833, 3'd0, 1'b0);
    exp_push(32'h1C, 32'h0000_1C33, 3'd0, 1'b0);
    exp_push(32'h20, 32'h0000_2033, 3'd0, 1'b0);
    exp_push(32'h24, 32'h0000_2433, 3'd0, 1'b0);
    drain("resume");
    if_ready = 1'b0;
    tick(4);

    // Phase C: 3-cycle memory, redirect with two requests in flight.
    mem_lat = 3;
    redir_on(32'h40);
    redir_off();
    tick(2);
    redir_on(32'h100);
    @(negedge clk);
    chk("c_pending_at_redirect", pend_q.size(), 32'd2);
    chk("c_rsp_at_redirect",     {31'h0, imem_rsp_valid}, 32'h0);
    redir_off();
    if_ready = 1'b1;
    exp_push(32'h100, 32'h0000_A103, 3'd1, 1'b0);
    exp_push(32'h104, 32'h0000_1297, 3'd4, 1'b0);
    exp_push(32'h108, 32'h0000_8067, 3'd1, 1'b0);
    drain("lat3_redirect");
    if_ready = 1'b0;
    tick(10);

    // Phase D: redirect in the same cycle as a response and a decode accept.
    mem_lat = 1;
    redir_on(32'h200);
    redir_off();
    if_ready = 1'b1;
    tick(2);
    redir_on(32'h300);
    @(negedge clk);
    chk("d_rsp_at_redirect",  {31'h0, imem_rsp_valid}, 32'h1);
    chk("d_head_at_redirect", {31'h0, if_valid}, 32'h1);
    redir_off();
    @(negedge clk);
    chk("d_empty_after_redirect", {31'h0, if_valid}, 32'h0);
    exp_push(32'h300, 32'h0000_0073, 3'd1, 1'b0);
    exp_push(32'h304, 32'h0003_0433, 3'd0, 1'b0);
    exp_push(32'h308, 32'h0003_0833, 3'd0, 1'b0);
    drain("coincident");
    if_ready = 1'b0;
    tick(4);

    // Phase E: PC wrap from 0xFFFF_FFFC to 0.
    redir_on(32'hFFFF_FFF8);
    redir_off();
    if_ready = 1'b1;
    exp_push(32'hFFFF_FFF8, 32'hFFFF_F833, 3'd0, 1'b0);
    exp_push(32'hFFFF_FFFC, 32'hFFFF_FC33, 3'd0, 1'b0);
    exp_push(32'h0000_0000, 32'h0050_0093, 3'd1, 1'b0);
    exp_push(32'h0000_0004, 32'h0010_2023, 3'd2, 1'b0);
    drain("wrap");
    if_ready = 1'b0;
    tick(4);

    // Phase F: misaligned redirect target.
`ifdef INST_FETCH_MISALIGN_CHECK_EN
    redir_on(32'h102);
    redir_off();
    fc = fire_count;
    if_ready = 1'b1;
    exp_push(32'h102, 32'h0000_0013, 3'd1, 1'b1);
    drain("misalign_marker");
    tick(5);
    @(negedge clk);
    chk("halt_req_valid",  {31'h0, imem_req_valid}, 32'h0);
    chk("halt_fire_count", fire_count, fc);
    tick(1);
    redir_on(32'h200);
    redir_off();
    exp_push(32'h200, 32'h0002_0033, 3'd0, 1'b0);
    exp_push(32'h204, 32'h0002_0433, 3'd0, 1'b0);
    drain("halt_release");
`else
    redir_on(32'h102);
    redir_off();
    fc = fire_count;
    if_ready = 1'b1;
    exp_push(32'h100, 32'h0000_A103, 3'd1, 1'b0);
    exp_push(32'h104, 32'h0000_1297, 3'd4, 1'b0);
    drain("misalign_forced");
    chk("forced_fetch_progress", {31'h0, (fire_count > fc)}, 32'h1);
`endif
    if_ready = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
